// File: rtl/comparador_pkg.sv
// comparador_pkg: result codes and the shared magnitude-compare function
package comparador_pkg;
  localparam int RES_W = 3;
  localparam int ANCHO_MAX = 32;
  localparam logic [RES_W-1:0] RES_MAYOR = 3'b100;
  localparam logic [RES_W-1:0] RES_MENOR = 3'b010;
  localparam logic [RES_W-1:0] RES_IGUAL = 3'b001;
  localparam logic [RES_W-1:0] RES_NINGUNO = 3'b000;
  // Operands arrive MSB-aligned so one width serves any ANCHO in both modes
  function automatic logic [RES_W-1:0] comparar(input logic [ANCHO_MAX-1:0] a, input logic [ANCHO_MAX-1:0] b, input logic signo);
    logic mayor;
    mayor = signo ? ($signed(a) > $signed(b)) : (a > b);
    return (a == b) ? RES_IGUAL : mayor ? RES_MAYOR : RES_MENOR;
  endfunction
endpackage

// File: rtl/comparador_canal.sv
// comparador_canal: one channel's compare, persistence tracking and output registers
module comparador_canal
  import comparador_pkg::*;
#(
  parameter int ANCHO = 4,
  parameter int UMBRAL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carga,
  input  logic             signo,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic [RES_W-1:0] salida,
  output logic             estable,
  output logic             cambio
);
  localparam int CW = $clog2(UMBRAL + 1);
  logic [ANCHO_MAX-1:0] a_al, b_al;
  logic [RES_W-1:0] ultimo, r;
  logic [CW-1:0] cuenta, cuenta_n;
  always_comb begin
    a_al = ANCHO_MAX'(a) << (ANCHO_MAX - ANCHO);
    b_al = ANCHO_MAX'(b) << (ANCHO_MAX - ANCHO);
    r = comparar(a_al, b_al, signo);
    cuenta_n = (r != ultimo) ? CW'(1) : (cuenta >= CW'(UMBRAL)) ? cuenta : cuenta + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ultimo <= RES_NINGUNO;
      cuenta <= '0;
      estable <= 1'b0;
      cambio <= 1'b0;
    end else if (carga) begin
      ultimo <= r;
      cuenta <= cuenta_n;
      estable <= cuenta_n >= CW'(UMBRAL);
      cambio <= r != ultimo;
    end
  end
  // The visible result is always the last accepted one
  assign salida = ultimo;
endmodule

// File: rtl/comparador_canales.sv
// comparador_canales: CANALES parallel magnitude comparators behind a one-stage valid/ready register
module comparador_canales
  import comparador_pkg::*;
#(
  parameter int ANCHO = 4,
  parameter int CANALES = 2,
  parameter int UMBRAL = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     modo_signo,
  input  logic                     valido_in,
  output logic                     listo_in,
  input  logic [CANALES*ANCHO-1:0] entradaA,
  input  logic [CANALES*ANCHO-1:0] entradaB,
  output logic                     valido_out,
  input  logic                     listo_out,
  output logic [CANALES*RES_W-1:0] salida,
  output logic [CANALES-1:0]       estable,
  output logic [CANALES-1:0]       cambio
);
  logic acepta;
  assign listo_in = !rst_n || !valido_out || listo_out;
  assign acepta = valido_in && listo_in;
  always_ff @(posedge clk) begin
    if (!rst_n) valido_out <= 1'b0;
    else valido_out <= acepta || (valido_out && !listo_out);
  end
  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    comparador_canal #(.ANCHO(ANCHO), .UMBRAL(UMBRAL)) u_canal (
      .clk(clk),
      .rst_n(rst_n),
      .carga(acepta),
      .signo(modo_signo),
      .a(entradaA[i*ANCHO +: ANCHO]),
      .b(entradaB[i*ANCHO +: ANCHO]),
      .salida(salida[i*RES_W +: RES_W]),
      .estable(estable[i]),
      .cambio(cambio[i])
    );
  end
endmodule

// File: tb/tb_comparador_canales.sv
// tb_comparador_canales: directed and model-checked stimulus for comparador_canales
module tb_comparador_canales;
  logic clk = 1'b0;
  logic rst_n, modo_signo, valido_in, listo_in, valido_out, listo_out;
  logic [7:0] entradaA, entradaB;
  logic [5:0] salida;
  logic [1:0] estable, cambio;
  int checks = 0;
  int failures = 0;
  int ult [2];
  int cnt [2];

  comparador_canales dut (
    .clk(clk), .rst_n(rst_n), .modo_signo(modo_signo), .valido_in(valido_in),
    .listo_in(listo_in), .entradaA(entradaA), .entradaB(entradaB),
    .valido_out(valido_out), .listo_out(listo_out), .salida(salida),
    .estable(estable), .cambio(cambio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] a1, input logic [3:0] b1, input logic s);
    entradaA = {a1, a0};
    entradaB = {b1, b0};
    modo_signo = s;
    valido_in = 1'b1;
  endtask

  task automatic outs(input string tag, input logic v, input logic [5:0] s, input logic [1:0] e, input logic [1:0] c);
    check({tag, ".valido"}, valido_out, v);
    check({tag, ".salida"}, salida, s);
    check({tag, ".estable"}, estable, e);
    check({tag, ".cambio"}, cambio, c);
  endtask

  function automatic logic [2:0] ref_cmp(input logic [3:0] a, input logic [3:0] b, input logic s);
    int va, vb;
    va = (s && a[3]) ? int'(a) - 16 : int'(a);
    vb = (s && b[3]) ? int'(b) - 16 : int'(b);
    return va > vb ? 3'b100 : va < vb ? 3'b010 : 3'b001;
  endfunction

  initial begin
    rst_n = 1'b0;
    listo_out = 1'b1;
    drive(4'd9, 4'd3, 4'd2, 4'd2, 1'b0);
    step();
    step();
    outs("reset", 1'b0, 6'b0, 2'b00, 2'b00);
    check("reset.listo_in", listo_in, 1'b1);
    rst_n = 1'b1;
    step();
    outs("unsigned", 1'b1, 6'b001_100, 2'b00, 2'b11);
    valido_in = 1'b0;
    step();
    check("drain.valido", valido_out, 1'b0);
    drive(4'b1000, 4'b0111, 4'd2, 4'd2, 1'b1);
    step();
    check("signed.salida", salida[2:0], 3'b010);
    drive(4'b1000, 4'b0111, 4'd2, 4'd2, 1'b0);
    step();
    check("unsigned_same.salida", salida[2:0], 3'b100);
    valido_in = 1'b0;
    step();
    listo_out = 1'b0;
    drive(4'd1, 4'd5, 4'd3, 4'd3, 1'b0);
    step();
    check("bp.first", salida, 6'b001_010);
    drive(4'd7, 4'd0, 4'd0, 4'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("bp.listo_in", listo_in, 1'b0);
      step();
      check("bp.hold_salida", salida, 6'b001_010);
      check("bp.hold_valido", valido_out, 1'b1);
    end
    listo_out = 1'b1;
    #1;
    check("bp.release_listo_in", listo_in, 1'b1);
    step();
    check("bp.new_salida", salida, 6'b010_100);
    check("bp.no_bubble", valido_out, 1'b1);
    valido_in = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    // ch0 A>B four times with idle gaps, ch1 always equal
    drive(4'd5, 4'd2, 4'd0, 4'd0, 1'b0);
    step();
    outs("pers1", 1'b1, 6'b001_100, 2'b00, 2'b11);
    valido_in = 1'b0;
    step();
    step();
    check("pers1.idle_estable", estable, 2'b00);
    drive(4'd5, 4'd2, 4'd0, 4'd0, 1'b0);
    step();
    outs("pers2", 1'b1, 6'b001_100, 2'b00, 2'b00);
    valido_in = 1'b0;
    step();
    drive(4'd5, 4'd2, 4'd0, 4'd0, 1'b0);
    step();
    outs("pers3", 1'b1, 6'b001_100, 2'b11, 2'b00);
    valido_in = 1'b0;
    step();
    step();
    check("pers3.idle_estable", estable, 2'b11);
    drive(4'd5, 4'd2, 4'd0, 4'd0, 1'b0);
    step();
    outs("pers4", 1'b1, 6'b001_100, 2'b11, 2'b00);
    drive(4'd4, 4'd4, 4'd0, 4'd0, 1'b0);
    step();
    outs("pers5", 1'b1, 6'b001_001, 2'b10, 2'b01);
    step();
    outs("pers6", 1'b1, 6'b001_001, 2'b10, 2'b00);
    step();
    outs("pers7", 1'b1, 6'b001_001, 2'b11, 2'b00);
    valido_in = 1'b0;
    listo_out = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.listo_in_comb", listo_in, 1'b1);
    step();
    outs("rst_mid", 1'b0, 6'b0, 2'b00, 2'b00);
    rst_n = 1'b1;
    listo_out = 1'b1;
    drive(4'd4, 4'd4, 4'd0, 4'd0, 1'b0);
    step();
    outs("post_rst", 1'b1, 6'b001_001, 2'b00, 2'b11);
    rst_n = 1'b0;
    valido_in = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      ult[c] = 0;
      cnt[c] = 0;
    end
    for (int t = 0; t < 16; t++) begin
      logic [5:0] es;
      logic [1:0] ee, ec;
      logic [2:0] r;
      drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      for (int c = 0; c < 2; c++) begin
        r = ref_cmp(entradaA[c*4 +: 4], entradaB[c*4 +: 4], modo_signo);
        ec[c] = int'(r) != ult[c];
        cnt[c] = ec[c] ? 1 : (cnt[c] >= 3 ? 3 : cnt[c] + 1);
        ult[c] = int'(r);
        ee[c] = cnt[c] >= 3;
        es[c*3 +: 3] = r;
      end
      step();
      outs("stream", 1'b1, es, ee, ec);
    end
    valido_in = 1'b0;
    step();
    check("stream.drain", valido_out, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comparador_canales.md
# comparador_canales

Multi-channel, pipelined successor to the team's single-pair magnitude comparator. Compares CANALES independent operand pairs per transaction, in unsigned or two's-complement mode, and registers the result. Tracks per-channel result persistence for glitch-free downstream decisions. Sits between sample producers (ADC/counter front ends) and control FSMs behind a valid/ready stream interface.

## Interface
- ANCHO, 4: bits per operand.
- CANALES, 2: number of independent comparison channels.
- UMBRAL, 3: consecutive identical results needed to assert `estable`. Legal range is ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- modo_signo  in  1  0 = unsigned, 1 = two's complement. Sampled with each accepted transaction.
- valido_in  in  1  input transaction valid.
- listo_in  out  1  block can accept an input this cycle.
- entradaA  in  CANALES*ANCHO  operand A; channel i occupies bits [i*ANCHO +: ANCHO].
- entradaB  in  CANALES*ANCHO  operand B; same packing as entradaA.
- valido_out  out  1  output register holds a result.
- listo_out  in  1  downstream accepts the result.
- salida  out  CANALES*3  per-channel one-hot result, channel i at [i*3 +: 3]:
  - 100 = A>B
  - 010 = A<B
  - 001 = A==B
  - 000 = no result
- estable  out  CANALES  channel result has repeated ≥UMBRAL consecutive accepted transactions.
- cambio  out  CANALES  channel result differs from that channel's previous accepted result.

## Operation
- Input is accepted when `valido_in && listo_in`.
- `listo_in = !valido_out || listo_out`: a single output stage with pass-through ready, no skid buffer.
- On accept, each channel:
  - computes its comparison using `modo_signo`;
  - loads `salida`;
  - updates its persistence state.
- Persistence state per channel:
  - `ultimo`: last result, 3 bits.
  - `cuenta`: saturating counter, width $clog2(UMBRAL+1).
- On accept, with new result `r`:
  - `r == ultimo`: `cuenta` increments, saturating at UMBRAL.
  - `r != ultimo`: `cuenta` = 1 and `cambio` = 1.
  - In both cases `ultimo` = `r`.
  - `estable` is registered as (new `cuenta` ≥ UMBRAL).
- `valido_out`:
  - set on accept;
  - cleared when `valido_out && listo_out` and there is no new accept in the same cycle.
- While `valido_out && !listo_out`: `salida`, `estable`, `cambio` and all state hold.
- Persistence state updates only on accepts, never on idle cycles.
- Reset (rst_n low at a clock edge) clears the following, overriding any handshake in progress:
  - `valido_out` = 0;
  - `salida` = 000 on all channels;
  - `estable` = 0, `cambio` = 0;
  - `ultimo` = 000, `cuenta` = 0.
- While rst_n is low, `listo_in` = 1 combinationally, but nothing is accepted.
- The first result after reset always gives `cambio` = 1 and `cuenta` = 1.
- With UMBRAL = 1, `estable` = 1 on every valid result.

## Timing
- Latency: accepted input appears on the outputs at the next rising edge (1 cycle).
- Throughput: 1 transaction/cycle when `listo_out` is held high.
- Simultaneous drain and accept in the same cycle:
  - the output register is overwritten with the new result;
  - `valido_out` stays 1;
  - no bubble.
- Outputs are fully registered. The only combinational path is `listo_out` → `listo_in`.
- `modo_signo` changing between transactions takes effect on the next accept only.

## Structure
- Package `comparador_pkg` holds:
  - result width constant `RES_W` = 3;
  - codes `RES_MAYOR` = 100, `RES_MENOR` = 010, `RES_IGUAL` = 001, `RES_NINGUNO` = 000;
  - compare function `comparar(a, b, signo)` returning the code.
- Sub-module `comparador_canal` contains:
  - one channel's compare logic;
  - its `ultimo` / `cuenta` state;
  - its output registers, with a load-enable input.
- Top level generates CANALES instances and owns the handshake logic (`valido_out`, `listo_in`).

## Test plan
- Unsigned, defaults: ch0 A=9,B=3; ch1 A=2,B=2 with `valido_in` = 1 → next cycle `valido_out` = 1, ch0 `salida` = 100, ch1 `salida` = 001, `cambio` = 11, `estable` = 00.
- Signed mode: ch0 A=1000b, B=0111b with `modo_signo` = 1 → 010 (−8 < 7). Same operands with `modo_signo` = 0 → 100.
- Backpressure: result pending, `listo_out` = 0 for 4 cycles while new inputs are offered → `listo_in` = 0 and outputs frozen. Raising `listo_out` drains the result and accepts the pending input in the same cycle.
- Persistence, UMBRAL=3, ch0 A>B on four accepts, then A==B → per accept:
  - `estable`: 0,0,1,1,0;
  - `cambio`: 1,0,0,0,1.
- Idle cycles between those accepts leave the counts unchanged.
- Reset mid-stream: `rst_n` low for one edge while `valido_out` = 1 and `cuenta` = 3 → all outputs 0. The first post-reset result gives `cambio` = 1, `estable` = 0.
- Streaming: 16 back-to-back random transactions with `listo_out` = 1 → 16 results on consecutive cycles, matching a reference model.
